ram_access_ctrl: RTL and testbench

Initiator-side controller for the 16×4 data RAM of the 4-bit computer. It turns a single-outstanding valid/ready request stream from the CPU datapath into RAM write-enable, address and data strobes. It absorbs the RAM's registered read latency and returns read data on a valid/ready response channel. After reset it optionally sweeps the RAM to a known value before accepting requests.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_access_ctrl.sv | 109 ++++++++++
 tb/tb_ram_access_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared widths and controller state encoding for the 16x4 data RAM path.
package ram_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 4;
  localparam int DEPTH     = 16;
  localparam int RAM_OUT_W = 16;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    IDLE      = 3'd1,
    WRITE     = 3'd2,
    READ_ADDR = 3'd3,
    READ_CAP  = 3'd4,
    RESP      = 3'd5
  } ram_ctrl_state_t;

endpackage

// File: rtl/ram_access_ctrl.sv
// Single-outstanding request controller for the 16x4 RAM: writes take 2 cycles, reads 4 (RAM read is registered).
// req_ready is high only in IDLE; a read response is held in RESP until rsp_ready.
module ram_access_ctrl
  import ram_pkg::*;
#(
  parameter bit                INIT_EN    = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = 4'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 init_done,
  output logic                 ram_write_en,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_dataIN,
  input  logic [RAM_OUT_W-1:0] ram_dataOut
);

  ram_ctrl_state_t state, state_n;

  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n;
  logic [DATA_W-1:0] rsp_data_n;

  // Only the low nibble of the RAM output carries data.
  logic unused_ram_hi;
  assign unused_ram_hi = ^ram_dataOut[RAM_OUT_W-1:DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT_EN ? INIT : IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    we_n       = 1'b0;
    addr_n     = ram_addr;
    data_n     = ram_dataIN;
    rsp_data_n = rsp_data;
    case (state)
      INIT: begin
        // ram_write_en doubles as the "sweep has started" flag: it is 0 only
        // straight out of reset, when address 0 still has to be presented.
        data_n = INIT_VALUE;
        if (ram_write_en && ram_addr == LAST_ADDR) begin
          state_n = IDLE;
        end else begin
          we_n   = 1'b1;
          addr_n = ram_write_en ? ram_addr + 4'd1 : '0;
        end
      end
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_n = req_addr;
          if (req_write) begin
            data_n  = req_wdata;
            we_n    = 1'b1;
            state_n = WRITE;
          end else begin
            state_n = READ_ADDR;
          end
        end
      end
      WRITE:     state_n = IDLE;
      READ_ADDR: state_n = READ_CAP;
      READ_CAP: begin
        rsp_data_n = ram_dataOut[DATA_W-1:0];
        state_n    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // All outputs are registered from the next state so nothing glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      init_done    <= 1'b0;
      ram_write_en <= 1'b0;
      ram_addr     <= '0;
      ram_dataIN   <= '0;
    end else begin
      req_ready    <= (state_n == IDLE);
      rsp_valid    <= (state_n == RESP);
      rsp_data     <= rsp_data_n;
      init_done    <= init_done | (state_n != INIT);
      ram_write_en <= we_n;
      ram_addr     <= addr_n;
      ram_dataIN   <= data_n;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench: two controllers (sweep enabled / disabled), each driving a registered-read RAM model.
module tb_ram_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Controller with sweep, INIT_VALUE = A
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [3:0]  req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, init_done, ram_write_en;
  logic [3:0]  rsp_data, ram_addr, ram_dataIN;
  logic [15:0] ram_dataOut;
  logic [3:0]  mem [16];

  // Controller without sweep
  logic        z_rst = 1'b1;
  logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_rsp_ready = 1'b1;
  logic [3:0]  z_req_addr = '0, z_req_wdata = '0;
  logic        z_req_ready, z_rsp_valid, z_init_done, z_ram_write_en;
  logic [3:0]  z_rsp_data, z_ram_addr, z_ram_dataIN;
  logic [15:0] z_ram_dataOut;
  logic [3:0]  z_mem [16];

  int checks = 0;
  int errors = 0;

  ram_access_ctrl #(.INIT_EN(1'b1), .INIT_VALUE(4'hA)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_dataIN(ram_dataIN), .ram_dataOut(ram_dataOut)
  );

  ram_access_ctrl #(.INIT_EN(1'b0), .INIT_VALUE(4'h0)) dut0 (
    .clk(clk), .rst(z_rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_data(z_rsp_data),
    .init_done(z_init_done), .ram_write_en(z_ram_write_en), .ram_addr(z_ram_addr),
    .ram_dataIN(z_ram_dataIN), .ram_dataOut(z_ram_dataOut)
  );

  // RAM models: write commits on the edge, read output registered and frozen during writes.
  // Upper output bits carry junk that the controller must ignore.
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr] <= ram_dataIN;
    else              ram_dataOut <= {12'hF5C, mem[ram_addr]};
  end

  always @(posedge clk) begin
    if (z_ram_write_en) z_mem[z_ram_addr] <= z_ram_dataIN;
    else                z_ram_dataOut <= {12'h3A7, z_mem[z_ram_addr]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_all();
    return {17'd0, req_ready, rsp_valid, rsp_data, init_done, ram_write_en, ram_addr, ram_dataIN};
  endfunction

  // Waits (bounded) for init_done after reset release; records what the first cycle drove.
  task automatic wait_done(output int cyc, output logic [31:0] first);
    cyc = 0;
    first = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) first = {23'd0, ram_write_en, ram_addr, ram_dataIN};
      if (init_done) break;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    check("wr_strobe", {ram_write_en, req_ready, ram_addr, ram_dataIN}, {1'b1, 1'b0, a, d});
    @(negedge clk);
    check("wr_done", {ram_write_en, req_ready}, 2'b01);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] exp);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    check("rd_e0", {ram_write_en, rsp_valid, req_ready, ram_addr}, {3'b000, a});
    @(negedge clk);
    check("rd_e1", {ram_write_en, rsp_valid, req_ready}, 3'b000);
    @(negedge clk);
    check("rd_rsp", {ram_write_en, rsp_valid, req_ready, rsp_data}, {3'b010, exp});
    @(negedge clk);
    check("rd_done", {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    int          cyc;
    logic [31:0] first;

    for (int i = 0; i < 16; i++) begin
      mem[i]   = 4'h3;
      z_mem[i] = 4'h6;
    end

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_outs", outs_all(), 32'd0);
    check("reset_outs_z", {z_req_ready, z_rsp_valid, z_init_done, z_ram_write_en}, 4'b0000);

    // Sweep: done 16 cycles after the first edge after release
    rst = 1'b0;
    wait_done(cyc, first);
    check("sweep_cycles", cyc, 17);
    check("sweep_first", first, {23'd0, 1'b1, 4'h0, 4'hA});
    check("sweep_end", {init_done, req_ready, ram_write_en}, 3'b110);

    do_read(4'd0, 4'hA);
    do_read(4'd7, 4'hA);
    do_read(4'd15, 4'hA);

    // Read-after-write back to back
    do_write(4'd3, 4'h5);
    do_read(4'd3, 4'h5);

    // Fill with data = addr, read back in reverse
    for (int a = 0; a < 16; a++) do_write(4'(a), 4'(a));
    for (int a = 15; a >= 0; a--) do_read(4'(a), 4'(a));

    // Response backpressure: stays in RESP, offered request is ignored
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd9;
    @(negedge clk);
    req_write = 1'b1; req_wdata = 4'hE;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("hold_resp", {rsp_valid, rsp_data, req_ready, ram_write_en}, {1'b1, 4'h9, 2'b00});
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check("hold_last", {rsp_valid, rsp_data}, {1'b1, 4'h9});
    @(negedge clk);
    check("hold_release", {rsp_valid, req_ready}, 2'b01);
    do_read(4'd9, 4'h9);

    // Reset while in READ_CAP
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_readcap", outs_all(), 32'd0);
    @(negedge clk);
    check("rst_readcap_held", outs_all(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("restart_first", {rsp_valid, ram_write_en, ram_addr, ram_dataIN}, {2'b01, 4'h0, 4'hA});

    // Reset while the sweep is driving address 6
    repeat (6) @(negedge clk);
    check("sweep_at6", {ram_write_en, ram_addr, init_done}, {1'b1, 4'h6, 1'b0});
    rst = 1'b1;
    #1;
    check("rst_sweep", outs_all(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_done(cyc, first);
    check("resweep_cycles", cyc, 17);
    check("resweep_first", first, {23'd0, 1'b1, 4'h0, 4'hA});
    check("resweep_no_rsp", rsp_valid, 1'b0);
    do_read(4'd6, 4'hA);
    do_read(4'd5, 4'hA);

    // No-sweep variant: ready one edge after release, write accepted then commits
    check("z_in_reset", {z_req_ready, z_init_done, z_ram_write_en}, 3'b000);
    z_rst = 1'b0;
    @(negedge clk);
    check("z_first_edge", {z_init_done, z_req_ready, z_ram_write_en}, 3'b110);
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 4'd2; z_req_wdata = 4'h7;
    @(negedge clk);
    z_req_valid = 1'b0;
    check("z_wr_strobe", {z_ram_write_en, z_ram_addr, z_ram_dataIN}, {1'b1, 4'h2, 4'h7});
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 4'd2;
    @(negedge clk);
    z_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("z_rd_rsp", {z_rsp_valid, z_rsp_data}, {1'b1, 4'h7});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
